io_wr_arbiter: RTL and testbench

Shares the single write port of the memory-mapped output buffer (LEDR/LEDG/HEX0-7/LCD region, 0x7000-0x70FF) between two masters.
- Port 0 is the single-cycle core LSU and always wins.
- Port 1 is a secondary master (debug/UART loader) with valid/ready handshake. Its writes are queued in a small FIFO and drained in cycles where the core is not writing the IO region.
- The block sits between the LSU/debug logic and the output buffer's wren/addr/func3/wdata inputs.

---
 rtl/io_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_io_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/io_wr_arbiter.sv
// Arbitrates the IO output-buffer write port: the core LSU always wins, debug writes wait in a FIFO.
// Define IOARB_STALL_EN to stall the core once after a run of busy cycles while debug writes wait.
module io_wr_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter logic [7:0]  IO_PAGE      = 8'h70
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_core_wren,
  input  logic [31:0]              i_core_addr,
  input  logic [2:0]               i_core_func3,
  input  logic [31:0]              i_core_wdata,
  input  logic                     i_dbg_valid,
  output logic                     o_dbg_ready,
  input  logic [31:0]              i_dbg_addr,
  input  logic [2:0]               i_dbg_func3,
  input  logic [31:0]              i_dbg_wdata,
  output logic                     o_buf_wren,
  output logic [31:0]              o_buf_addr,
  output logic [2:0]               o_buf_func3,
  output logic [31:0]              o_buf_wdata,
  output logic                     o_dbg_drop,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic                     o_core_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 32 + 3 + 32;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          core_io, core_sel, empty, full, dbg_ok, push, pop;
  logic [EW-1:0] head;

  assign core_io  = i_core_wren && (i_core_addr[15:8] == IO_PAGE);
  assign core_sel = core_io && !o_core_stall;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dbg_ok   = (i_dbg_addr[15:8] == IO_PAGE) && (i_dbg_func3[1:0] != 2'b11);
  assign push     = i_dbg_valid && !full && dbg_ok;
  assign pop      = !core_sel && !empty;
  assign head     = mem[rptr[AW-1:0]];

  // Ready reflects the registered level only; a pop in the same cycle does not free a slot early.
  assign o_dbg_ready = !full;

  // Write-port mux; the strobe is held low for as long as reset is asserted.
  always_comb begin
    o_buf_wren  = 1'b0;
    o_buf_addr  = 32'd0;
    o_buf_func3 = 3'd0;
    o_buf_wdata = 32'd0;
    if (i_rst_n) begin
      if (core_sel) begin
        o_buf_wren  = 1'b1;
        o_buf_addr  = i_core_addr;
        o_buf_func3 = i_core_func3;
        o_buf_wdata = i_core_wdata;
      end else if (!empty) begin
        o_buf_wren  = 1'b1;
        o_buf_addr  = head[EW-1 -: 32];
        o_buf_func3 = head[31+3 -: 3];
        o_buf_wdata = head[31:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr[AW-1:0]] <= {i_dbg_addr, i_dbg_func3, i_dbg_wdata};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      o_fifo_level <= '0;
      o_dbg_drop   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      o_fifo_level <= o_fifo_level + PW'(push) - PW'(pop);
      o_dbg_drop   <= i_dbg_valid && !full && !dbg_ok;
    end
  end

`ifdef IOARB_STALL_EN
  typedef enum logic [1:0] {IDLE, COUNT, STALL} state_t;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  state_t        state;
  logic [CW-1:0] starve_cnt;

  // Counts consecutive cycles the core blocks a waiting debug write; the first busy cycle counts as 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      o_core_stall <= 1'b0;
    end else begin
      o_core_stall <= 1'b0;
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          if (core_io && !empty) begin
            state      <= COUNT;
            starve_cnt <= CW'(1);
          end
        end
        COUNT: begin
          if (!core_io || empty) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end else if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
            state        <= STALL;
            starve_cnt   <= '0;
            o_core_stall <= 1'b1;
          end else begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        STALL: begin
          state      <= IDLE;
          starve_cnt <= '0;
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= '0;
        end
      endcase
    end
  end
`else
  assign o_core_stall = 1'b0;
`endif

endmodule

// File: tb/tb_io_wr_arbiter.sv
// Scoreboard bench for io_wr_arbiter; accepted debug writes are queued and retired as the DUT issues them.
module tb_io_wr_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_wren = 1'b0;
  logic [31:0] core_addr = '0;
  logic [2:0]  core_func3 = '0;
  logic [31:0] core_wdata = '0;
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic [31:0] dbg_addr = '0;
  logic [2:0]  dbg_func3 = '0;
  logic [31:0] dbg_wdata = '0;
  logic        buf_wren;
  logic [31:0] buf_addr;
  logic [2:0]  buf_func3;
  logic [31:0] buf_wdata;
  logic        dbg_drop;
  logic [2:0]  fifo_level;
  logic        core_stall;

  io_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .IO_PAGE(8'h70)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_wren(core_wren), .i_core_addr(core_addr), .i_core_func3(core_func3), .i_core_wdata(core_wdata),
    .i_dbg_valid(dbg_valid), .o_dbg_ready(dbg_ready),
    .i_dbg_addr(dbg_addr), .i_dbg_func3(dbg_func3), .i_dbg_wdata(dbg_wdata),
    .o_buf_wren(buf_wren), .o_buf_addr(buf_addr), .o_buf_func3(buf_func3), .o_buf_wdata(buf_wdata),
    .o_dbg_drop(dbg_drop), .o_fifo_level(fifo_level), .o_core_stall(core_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  func3;
    logic [31:0] wdata;
  } wr_t;

  wr_t  exp_q[$];
  logic exp_drop  = 1'b0;
  logic exp_stall = 1'b0;
  int   starve    = 0;
  int   errors    = 0;
  int   checks    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_core(input logic en, input logic [31:0] a, input logic [31:0] d);
    core_wren  = en;
    core_addr  = a;
    core_func3 = 3'b010;
    core_wdata = d;
  endtask

  task automatic set_dbg(input logic v, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    dbg_valid = v;
    dbg_addr  = a;
    dbg_func3 = f;
    dbg_wdata = d;
  endtask

  // Check outputs mid-cycle, then advance the model by the coming rising edge.
  task automatic step();
    logic core_io, core_sel, acc, pass, nonempty;
    wr_t  e;
    @(negedge clk);
    core_io  = core_wren && (core_addr[15:8] == 8'h70);
    core_sel = core_io && !exp_stall;
    nonempty = exp_q.size() > 0;
    if (core_sel) begin
      e.addr = core_addr; e.func3 = core_func3; e.wdata = core_wdata;
    end else if (nonempty) begin
      e = exp_q[0];
    end else begin
      e = '0;
    end
    check("buf_wren",   32'(buf_wren),   32'(core_sel || nonempty));
    check("buf_addr",   buf_addr,        e.addr);
    check("buf_func3",  32'(buf_func3),  32'(e.func3));
    check("buf_wdata",  buf_wdata,       e.wdata);
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("dbg_ready",  32'(dbg_ready),  32'(exp_q.size() < DEPTH));
    check("dbg_drop",   32'(dbg_drop),   32'(exp_drop));
    check("core_stall", 32'(core_stall), 32'(exp_stall));
    acc  = dbg_valid && (exp_q.size() < DEPTH);
    pass = (dbg_addr[15:8] == 8'h70) && (dbg_func3[1:0] != 2'b11);
`ifdef IOARB_STALL_EN
    if (exp_stall || !(core_io && nonempty)) begin
      starve = 0; exp_stall = 1'b0;
    end else begin
      starve++;
      if (starve == LIMIT) begin exp_stall = 1'b1; starve = 0; end
    end
`endif
    if (!core_sel && nonempty) void'(exp_q.pop_front());
    if (acc && pass) begin
      e.addr = dbg_addr; e.func3 = dbg_func3; e.wdata = dbg_wdata;
      exp_q.push_back(e);
    end
    exp_drop = acc && !pass;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state, with a core IO store present to show the strobe is gated
    set_core(1'b1, 32'h7010, 32'hDEAD0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_wren",  32'(buf_wren),   32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop",  32'(dbg_drop),   32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    set_core(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(dbg_ready), 32'd1);

    // Single debug write with idle core
    set_dbg(1'b1, 32'h7000, 3'b010, 32'h12345678);
    step();
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    steps(3);

    // Core busy 5 cycles, 2 debug pushes (first targets the same address as the core)
    set_core(1'b1, 32'h7020, 32'hC0C0C0C0);
    set_dbg(1'b1, 32'h7020, 3'b000, 32'h000000AA);
    step();
    set_dbg(1'b1, 32'h7024, 3'b001, 32'h0000BEEF);
    step();
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    steps(3);
    set_core(1'b0, 32'h0, 32'h0);
    steps(3);

    // Fill to DEPTH with core busy; a 5th request is held until a slot frees
    set_core(1'b1, 32'h7030, 32'h11111111);
    for (int i = 0; i < 4; i++) begin
      set_dbg(1'b1, 32'h7040 + 32'(i * 4), 3'b010, 32'hA0 + 32'(i));
      step();
    end
    set_dbg(1'b1, 32'h7050, 3'b010, 32'h000000A4);
    steps(3);
    set_core(1'b0, 32'h0, 32'h0);
    steps(2);
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    steps(6);

    // Filtered requests: non-IO page and reserved size
    set_dbg(1'b1, 32'h1000, 3'b010, 32'h55555555);
    step();
    set_dbg(1'b1, 32'h7008, 3'b011, 32'h66666666);
    step();
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    steps(3);

    // Core keeps the port busy while one debug entry waits
    set_dbg(1'b1, 32'h7060, 3'b010, 32'h77777777);
    step();
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    set_core(1'b1, 32'h70F0, 32'h88888888);
    steps(LIMIT + 4);
    set_core(1'b0, 32'h0, 32'h0);
    steps(3);

    // Reset with 3 entries queued and the core writing
    set_core(1'b1, 32'h7070, 32'h99999999);
    for (int i = 0; i < 3; i++) begin
      set_dbg(1'b1, 32'h7080 + 32'(i), 3'b000, 32'hB0 + 32'(i));
      step();
    end
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wren",  32'(buf_wren),   32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_stall", 32'(core_stall), 32'd0);
    exp_q.delete();
    exp_drop = 1'b0; exp_stall = 1'b0; starve = 0;
    set_core(1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(dbg_ready), 32'd1);
    steps(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_core($urandom_range(0, 2) != 0,
               ($urandom_range(0, 5) == 0) ? 32'h2000 : 32'h7000 + 32'($urandom_range(0, 255)),
               $urandom);
      set_dbg($urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? 32'h1234 : 32'h7000 + 32'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), $urandom);
      step();
    end
    set_core(1'b0, 32'h0, 32'h0);
    set_dbg(1'b0, 32'h0, 3'b000, 32'h0);
    steps(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
